core_seq_ctrl: RTL
==================

// Module: core_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer for the RV32 core. It replaces the single-cycle top's free-running PC
//  and always-on memory with an FSM. The FSM owns the PC register and runs each instruction
//  through fetch, execute, memory and writeback, using valid/ready handshakes to IFU and LSU.
//  IDU/EXU stay combinational on the latched instruction; this block gates RF write and PC update.
// PARAMETERS
//  XLEN      32            datapath/address width
//  RESET_PC  32'h8000_0000 PC value loaded on reset
//  TIMEOUT   255           max cycles in any *_WAIT/*_REQ state before bus-timeout halt (>=1)
// PORTS
//  clk            in   1     clock, rising edge
//  rst            in   1     reset, asynchronous, active-low
//  pc             out  XLEN  current PC
//  inst           out  32    latched instruction, feeds IDU
//  ifu_req_valid  out  1     fetch request; ifu_req_addr = pc
//  ifu_req_addr   out  XLEN  fetch address
//  ifu_req_ready  in   1     IFU accepts request
//  ifu_rsp_valid  in   1     fetch data valid
//  ifu_rsp_data   in   32    fetched instruction
//  ifu_rsp_ready  out  1     sequencer accepts fetch data
//  dec_mem_rd     in   1     IDU: load
//  dec_mem_wr     in   1     IDU: store
//  dec_reg_wen    in   1     IDU: instruction writes rd
//  dec_ebreak     in   1     IDU: ebreak
//  dec_wmask      in   4     IDU: store byte mask
//  exu_result     in   XLEN  EXU ALU/link result
//  exu_addr       in   XLEN  EXU effective address (rs1+imm)
//  exu_wdata      in   XLEN  store data (rs2)
//  exu_next_pc    in   XLEN  EXU next PC (pc+4 / branch / jump target)
//  lsu_req_valid  out  1     data request
//  lsu_req_we     out  1     1=store
//  lsu_req_addr   out  XLEN  data address
//  lsu_req_wdata  out  XLEN  store data
//  lsu_req_wmask  out  4     store byte mask
//  lsu_req_ready  in   1     LSU accepts request
//  lsu_rsp_valid  in   1     load data / store ack valid
//  lsu_rsp_data   in   XLEN  load data, already extended by LSU
//  lsu_rsp_ready  out  1     sequencer accepts response
//  rf_wen         out  1     register file write enable (1-cycle pulse)
//  rf_wdata       out  XLEN  register file write data
//  commit         out  1     1-cycle pulse per retired instruction
//  halt           out  1     sticky halt
//  halt_cause     out  2     0 running, 1 ebreak, 2 bus timeout, 3 misaligned next PC
// BEHAVIOUR
//  States: FETCH_REQ, FETCH_WAIT, EXEC, MEM_REQ, MEM_WAIT, WB, HALT.
//  Reset: state=FETCH_REQ, pc=RESET_PC, inst=0, timeout counter=0, all latches=0.
//   Every valid/ready/wen/commit/halt output is 0 and halt_cause=0 in reset.
//   Reset is async mid-operation; any in-flight transaction is dropped.
//  FETCH_REQ: ifu_req_valid=1. On ifu_req_ready -> FETCH_WAIT.
//  FETCH_WAIT: ifu_rsp_ready=1. On ifu_rsp_valid: inst<=ifu_rsp_data -> EXEC.
//  EXEC: 1 cycle, evaluated in priority order:
//   1. dec_ebreak -> HALT with cause 1.
//   2. exu_next_pc[1:0]!=0 -> HALT with cause 3.
//   3. Otherwise latch next_pc, result, addr, wdata, wmask and we=dec_mem_wr.
//      Go to MEM_REQ if dec_mem_rd|dec_mem_wr, else to WB.
//  MEM_REQ: lsu_req_valid=1 with latched fields. On lsu_req_ready -> MEM_WAIT.
//  MEM_WAIT: lsu_rsp_ready=1. On lsu_rsp_valid: for a load, result<=lsu_rsp_data. Then -> WB.
//  WB: commit=1; rf_wen=dec_reg_wen&~we; rf_wdata=result; pc<=next_pc -> FETCH_REQ.
//  HALT: absorbing until reset. halt=1, no requests issued, pc frozen.
//  Handshake: valid, once raised, stays high with stable addr/data until ready; never withdrawn.
//   Valid&ready in the same cycle as it rises is a legal 1-cycle transfer.
//   Responses outside *_WAIT are ignored (rsp_ready=0).
//  Timeout: counter clears on entry to each REQ/WAIT state and increments per stalled cycle.
//   Reaching TIMEOUT -> HALT with cause 2. rf_wen and commit are never asserted on halt.
//  Latency with zero-wait ready/rsp: ALU/branch = 4 cycles, load/store = 6 cycles per instruction.
//  Arithmetic: pc is replaced by exu_next_pc only; no internal adder; wrap is EXU's concern.
// TESTING
//  addi x1,x0,5 at 0x8000_0000, zero-wait -> rf_wen pulse with wdata=5 at cycle 4, pc=0x8000_0004.
//  lw, LSU returns 0xDEAD_BEEF after 3 stall cycles -> rf_wdata=0xDEADBEEF, commit at cycle 9.
//  sw with wmask=4'b0011 -> lsu_req_we=1 and mask held stable while ready=0; rf_wen stays 0.
//  ifu_req_ready stuck 0 for TIMEOUT=8 -> halt=1, halt_cause=2, no commit.
//  beq target 0x8000_0102 -> halt_cause=3. ebreak -> halt_cause=1, pc frozen.
//  rst low during MEM_WAIT -> pc=0x8000_0000 and state FETCH_REQ on release; late lsu_rsp ignored.

Source files
------------

// File: rtl/core_seq_ctrl_if.sv
// Fetch (IFU) and data (LSU) valid/ready channels between the sequencer and memory side.
// master = sequencer, slave = IFU/LSU.
interface core_seq_ctrl_if #(
  parameter int XLEN = 32
);
  logic            ifu_req_valid;
  logic [XLEN-1:0] ifu_req_addr;
  logic            ifu_req_ready;
  logic            ifu_rsp_valid;
  logic [31:0]     ifu_rsp_data;
  logic            ifu_rsp_ready;

  logic            lsu_req_valid;
  logic            lsu_req_we;
  logic [XLEN-1:0] lsu_req_addr;
  logic [XLEN-1:0] lsu_req_wdata;
  logic [3:0]      lsu_req_wmask;
  logic            lsu_req_ready;
  logic            lsu_rsp_valid;
  logic [XLEN-1:0] lsu_rsp_data;
  logic            lsu_rsp_ready;

  modport master (
    output ifu_req_valid, ifu_req_addr, ifu_rsp_ready,
    output lsu_req_valid, lsu_req_we, lsu_req_addr, lsu_req_wdata, lsu_req_wmask, lsu_rsp_ready,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_data
  );

  modport slave (
    input  ifu_req_valid, ifu_req_addr, ifu_rsp_ready,
    input  lsu_req_valid, lsu_req_we, lsu_req_addr, lsu_req_wdata, lsu_req_wmask, lsu_rsp_ready,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
    output lsu_req_ready, lsu_rsp_valid, lsu_rsp_data
  );
endinterface

// File: rtl/core_seq_ctrl.sv
// Multi-cycle RV32 sequencer: owns the PC and steps each instruction through
// fetch, execute, memory and writeback with a per-handshake bus timeout.
module core_seq_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000),
  parameter int              TIMEOUT  = 255
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  core_seq_ctrl_if.master  bus,
  output logic [XLEN-1:0]  pc_o,
  output logic [31:0]      inst_o,
  input  logic             dec_mem_rd_i,
  input  logic             dec_mem_wr_i,
  input  logic             dec_reg_wen_i,
  input  logic             dec_ebreak_i,
  input  logic [3:0]       dec_wmask_i,
  input  logic [XLEN-1:0]  exu_result_i,
  input  logic [XLEN-1:0]  exu_addr_i,
  input  logic [XLEN-1:0]  exu_wdata_i,
  input  logic [XLEN-1:0]  exu_next_pc_i,
  output logic             rf_wen_o,
  output logic [XLEN-1:0]  rf_wdata_o,
  output logic             commit_o,
  output logic             halt_o,
  output logic [1:0]       halt_cause_o
);

  localparam logic [2:0] S_FETCH_REQ  = 3'd0;
  localparam logic [2:0] S_FETCH_WAIT = 3'd1;
  localparam logic [2:0] S_EXEC       = 3'd2;
  localparam logic [2:0] S_MEM_REQ    = 3'd3;
  localparam logic [2:0] S_MEM_WAIT   = 3'd4;
  localparam logic [2:0] S_WB         = 3'd5;
  localparam logic [2:0] S_HALT       = 3'd6;

  localparam logic [1:0] CAUSE_EBREAK  = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;
  localparam logic [1:0] CAUSE_MISALGN = 2'd3;

  // Counter only needs to reach TIMEOUT-1; the next stalled cycle halts.
  localparam int              CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [2:0]      state_q,   state_d;
  logic [XLEN-1:0] pc_q,      pc_d;
  logic [31:0]     inst_q,    inst_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [XLEN-1:0] next_pc_q, next_pc_d;
  logic [XLEN-1:0] result_q,  result_d;
  logic [XLEN-1:0] addr_q,    addr_d;
  logic [XLEN-1:0] wdata_q,   wdata_d;
  logic [3:0]      wmask_q,   wmask_d;
  logic            we_q,      we_d;
  logic [1:0]      cause_q,   cause_d;

  logic in_bus;
  logic xfer;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    next_pc_d = next_pc_q;
    result_d  = result_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    we_d      = we_q;
    cause_d   = cause_q;
    in_bus    = 1'b0;
    xfer      = 1'b0;

    case (state_q)
      S_FETCH_REQ: begin
        in_bus = 1'b1;
        if (bus.ifu_req_ready) begin
          xfer    = 1'b1;
          state_d = S_FETCH_WAIT;
        end
      end
      S_FETCH_WAIT: begin
        in_bus = 1'b1;
        if (bus.ifu_rsp_valid) begin
          xfer    = 1'b1;
          inst_d  = bus.ifu_rsp_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (dec_ebreak_i) begin
          cause_d = CAUSE_EBREAK;
          state_d = S_HALT;
        end else if (exu_next_pc_i[1:0] != 2'b00) begin
          cause_d = CAUSE_MISALGN;
          state_d = S_HALT;
        end else begin
          next_pc_d = exu_next_pc_i;
          result_d  = exu_result_i;
          addr_d    = exu_addr_i;
          wdata_d   = exu_wdata_i;
          wmask_d   = dec_wmask_i;
          we_d      = dec_mem_wr_i;
          state_d   = (dec_mem_rd_i | dec_mem_wr_i) ? S_MEM_REQ : S_WB;
        end
      end
      S_MEM_REQ: begin
        in_bus = 1'b1;
        if (bus.lsu_req_ready) begin
          xfer    = 1'b1;
          state_d = S_MEM_WAIT;
        end
      end
      S_MEM_WAIT: begin
        in_bus = 1'b1;
        if (bus.lsu_rsp_valid) begin
          xfer = 1'b1;
          if (!we_q) result_d = bus.lsu_rsp_data;
          state_d = S_WB;
        end
      end
      S_WB: begin
        pc_d    = next_pc_q;
        state_d = S_FETCH_REQ;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase

    // Any cycle not stalled in a bus state leaves the counter at zero for the next entry.
    cnt_d = '0;
    if (in_bus && !xfer) begin
      if (cnt_q == CNT_LAST) begin
        cause_d = CAUSE_TIMEOUT;
        state_d = S_HALT;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_FETCH_REQ;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      cnt_q     <= '0;
      next_pc_q <= '0;
      result_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      we_q      <= 1'b0;
      cause_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      cnt_q     <= cnt_d;
      next_pc_q <= next_pc_d;
      result_q  <= result_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wmask_q   <= wmask_d;
      we_q      <= we_d;
      cause_q   <= cause_d;
    end
  end

  // Reset parks the FSM in FETCH_REQ, so the fetch request is masked while rst_ni is low.
  assign bus.ifu_req_valid = rst_ni && (state_q == S_FETCH_REQ);
  assign bus.ifu_req_addr  = pc_q;
  assign bus.ifu_rsp_ready = (state_q == S_FETCH_WAIT);

  assign bus.lsu_req_valid = (state_q == S_MEM_REQ);
  assign bus.lsu_req_we    = we_q;
  assign bus.lsu_req_addr  = addr_q;
  assign bus.lsu_req_wdata = wdata_q;
  assign bus.lsu_req_wmask = wmask_q;
  assign bus.lsu_rsp_ready = (state_q == S_MEM_WAIT);

  assign pc_o         = pc_q;
  assign inst_o       = inst_q;
  assign commit_o     = (state_q == S_WB);
  assign rf_wen_o     = commit_o && dec_reg_wen_i && !we_q;
  assign rf_wdata_o   = result_q;
  assign halt_o       = (state_q == S_HALT);
  assign halt_cause_o = cause_q;

endmodule
